// File: rtl/mem_refill_arbiter_pkg.sv
// Shared constants, types and small helpers for the memory refill arbiter.
// Tag layout: {port_id[1:0], requester_tag[DC_MEM_TAG_BITS-1:0]}.
package mem_refill_arbiter_pkg;

    localparam int MEM_ADDR_BITS   = 32;
    localparam int DC_MEM_TAG_BITS = 5;
    localparam int MEM_TAG_BITS    = DC_MEM_TAG_BITS + 2;
    localparam int CNT_BITS        = 3;

    typedef logic [1:0] port_id_t;

    localparam port_id_t PORT_DC  = 2'd0;
    localparam port_id_t PORT_ICC = 2'd1;
    localparam port_id_t PORT_ICV = 2'd2;
    localparam port_id_t PORT_BAD = 2'd3;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    typedef struct packed {
        logic                       rw;
        logic [MEM_ADDR_BITS-1:0]   addr;
        logic [DC_MEM_TAG_BITS-1:0] tag;
    } mem_req_t;

    function automatic logic [2:0] port_to_onehot(input port_id_t p);
        case (p)
            PORT_DC:  return 3'b001;
            PORT_ICC: return 3'b010;
            PORT_ICV: return 3'b100;
            default:  return 3'b000;
        endcase
    endfunction

    function automatic port_id_t onehot_to_port(input logic [2:0] oh);
        if (oh[2])      return PORT_ICV;
        else if (oh[1]) return PORT_ICC;
        else            return PORT_DC;
    endfunction

    function automatic port_id_t next_port(input port_id_t p);
        return (p >= PORT_ICV) ? PORT_DC : p + 2'd1;
    endfunction

endpackage

// File: rtl/mem_refill_arbiter_rr_pick3.sv
// Combinational 3-way round-robin selector: first eligible port at or after ptr,
// cyclic order 0->1->2->0.
module rr_pick3
    import mem_refill_arbiter_pkg::*;
(
    input  logic [2:0] eligible,
    input  port_id_t   ptr,
    output logic [2:0] sel,
    output logic       any
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default before any
        // branch, so no path leaves it unassigned and no latch is inferred.
        sel = 3'b000;
        case (ptr)
            PORT_ICC: sel = eligible[1] ? 3'b010 : eligible[2] ? 3'b100 :
                            eligible[0] ? 3'b001 : 3'b000;
            PORT_ICV: sel = eligible[2] ? 3'b100 : eligible[0] ? 3'b001 :
                            eligible[1] ? 3'b010 : 3'b000;
            default:  sel = eligible[0] ? 3'b001 : eligible[1] ? 3'b010 :
                            eligible[2] ? 3'b100 : 3'b000;
        endcase
    end

    assign any = |eligible;

endmodule

// File: rtl/mem_refill_arbiter.sv
// Round-robin, grant-locked arbiter sharing the memory refill port between the
// dcache (0), control icache (1) and vector icache (2), with per-port credit limits.
module mem_refill_arbiter
    import mem_refill_arbiter_pkg::*;
#(
    parameter int MAX_OUT = 4
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       dc_mem_req_val,
    output logic                       dc_mem_req_rdy,
    input  logic                       dc_mem_req_rw,
    input  logic [MEM_ADDR_BITS-1:0]   dc_mem_req_addr,
    input  logic [DC_MEM_TAG_BITS-1:0] dc_mem_req_tag,

    input  logic                       icc_mem_req_val,
    output logic                       icc_mem_req_rdy,
    input  logic [MEM_ADDR_BITS-1:0]   icc_mem_req_addr,
    input  logic                       icc_mem_req_tag,

    input  logic                       icv_mem_req_val,
    output logic                       icv_mem_req_rdy,
    input  logic [MEM_ADDR_BITS-1:0]   icv_mem_req_addr,
    input  logic                       icv_mem_req_tag,

    output logic                       dc_mem_resp_val,
    output logic                       dc_mem_resp_nack,
    output logic                       icc_mem_resp_val,
    output logic                       icc_mem_resp_nack,
    output logic                       icv_mem_resp_val,
    output logic                       icv_mem_resp_nack,

    output logic                       mem_req_val,
    input  logic                       mem_req_rdy,
    output logic                       mem_req_rw,
    output logic [MEM_ADDR_BITS-1:0]   mem_req_addr,
    output logic [MEM_TAG_BITS-1:0]    mem_req_tag,

    input  logic                       mem_resp_val,
    input  logic                       mem_resp_nack,
    input  logic [MEM_TAG_BITS-1:0]    mem_resp_tag,

    output logic                       tag_err
);

    localparam logic [CNT_BITS-1:0] MAX_CNT = CNT_BITS'(MAX_OUT);

    logic [0:0]          state_q;
    port_id_t            grant_q;
    port_id_t            rr_ptr_q;
    logic [CNT_BITS-1:0] cnt_q [3];
    logic                tag_err_q;

    logic [2:0] req_val;
    logic [2:0] eligible;
    logic [2:0] pick_sel;
    logic       pick_any;
    logic [2:0] sel;
    port_id_t   sel_port;
    mem_req_t   req_pl [3];
    mem_req_t   pl;
    logic       accept;
    logic [2:0] inc;
    logic [2:0] dec;
    logic [2:0] resp_hit;
    logic [2:0] cnt_zero;
    port_id_t   resp_port;
    logic       resp_evt;
    logic       bad_port;
    logic       underflow;

    assign req_val = {icv_mem_req_val, icc_mem_req_val, dc_mem_req_val};

    // Icache requests are read-only and carry a 1-bit tag, zero-extended.
    assign req_pl[0] = '{rw: dc_mem_req_rw, addr: dc_mem_req_addr, tag: dc_mem_req_tag};
    assign req_pl[1] = '{rw: 1'b0, addr: icc_mem_req_addr,
                         tag: {{(DC_MEM_TAG_BITS-1){1'b0}}, icc_mem_req_tag}};
    assign req_pl[2] = '{rw: 1'b0, addr: icv_mem_req_addr,
                         tag: {{(DC_MEM_TAG_BITS-1){1'b0}}, icv_mem_req_tag}};

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            eligible[i] = req_val[i] && (cnt_q[i] < MAX_CNT);
            cnt_zero[i] = (cnt_q[i] == '0);
        end
    end

    rr_pick3 u_pick (
        .eligible (eligible),
        .ptr      (rr_ptr_q),
        .sel      (pick_sel),
        .any      (pick_any)
    );

    // While locked only the granted port may drive; a dropped val deselects it.
    always_comb begin
        sel = pick_sel;
        if (state_q == ST_HOLD) sel = port_to_onehot(grant_q) & req_val;
    end

    assign sel_port = onehot_to_port(sel);

    always_comb begin
        pl = '0;
        for (int i = 0; i < 3; i++) begin
            if (sel[i]) pl = req_pl[i];
        end
    end

    assign mem_req_val  = |sel;
    assign mem_req_rw   = pl.rw;
    assign mem_req_addr = pl.addr;
    assign mem_req_tag  = {sel_port, pl.tag};

    assign accept = mem_req_val & mem_req_rdy;
    assign inc    = sel & {3{mem_req_rdy}};

    assign dc_mem_req_rdy  = inc[0];
    assign icc_mem_req_rdy = inc[1];
    assign icv_mem_req_rdy = inc[2];

    assign resp_port = mem_resp_tag[MEM_TAG_BITS-1 -: 2];
    assign resp_hit  = port_to_onehot(resp_port);
    assign resp_evt  = mem_resp_val | mem_resp_nack;
    assign dec       = resp_hit & {3{resp_evt}};

    assign dc_mem_resp_val   = mem_resp_val  & resp_hit[0];
    assign icc_mem_resp_val  = mem_resp_val  & resp_hit[1];
    assign icv_mem_resp_val  = mem_resp_val  & resp_hit[2];
    assign dc_mem_resp_nack  = mem_resp_nack & resp_hit[0];
    assign icc_mem_resp_nack = mem_resp_nack & resp_hit[1];
    assign icv_mem_resp_nack = mem_resp_nack & resp_hit[2];

    assign bad_port  = resp_evt & (resp_port == PORT_BAD);
    assign underflow = |(dec & ~inc & cnt_zero);
    assign tag_err   = tag_err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: state registers use non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            state_q  <= ST_IDLE;
            grant_q  <= PORT_DC;
            rr_ptr_q <= PORT_DC;
        end else begin
            if (accept) rr_ptr_q <= next_port(sel_port);
            case (state_q)
                ST_IDLE: begin
                    if (pick_any && !mem_req_rdy) begin
                        state_q <= ST_HOLD;
                        grant_q <= sel_port;
                    end
                end
                default: begin
                    if (accept || !mem_req_val) state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Same-cycle accept and response on one port cancel out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
            tag_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (inc[i] && !dec[i])
                    cnt_q[i] <= cnt_q[i] + CNT_BITS'(1);
                else if (dec[i] && !inc[i] && !cnt_zero[i])
                    cnt_q[i] <= cnt_q[i] - CNT_BITS'(1);
            end
            if (bad_port || underflow) tag_err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Directed bench for mem_refill_arbiter: fairness, grant lock, credit limits,
// response/nack steering, tag errors and asynchronous reset.
module tb_mem_refill_arbiter;
    import mem_refill_arbiter_pkg::*;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       dc_mem_req_val, dc_mem_req_rdy, dc_mem_req_rw;
    logic [MEM_ADDR_BITS-1:0]   dc_mem_req_addr;
    logic [DC_MEM_TAG_BITS-1:0] dc_mem_req_tag;
    logic                       icc_mem_req_val, icc_mem_req_rdy, icc_mem_req_tag;
    logic [MEM_ADDR_BITS-1:0]   icc_mem_req_addr;
    logic                       icv_mem_req_val, icv_mem_req_rdy, icv_mem_req_tag;
    logic [MEM_ADDR_BITS-1:0]   icv_mem_req_addr;
    logic                       dc_mem_resp_val, dc_mem_resp_nack;
    logic                       icc_mem_resp_val, icc_mem_resp_nack;
    logic                       icv_mem_resp_val, icv_mem_resp_nack;
    logic                       mem_req_val, mem_req_rdy, mem_req_rw;
    logic [MEM_ADDR_BITS-1:0]   mem_req_addr;
    logic [MEM_TAG_BITS-1:0]    mem_req_tag;
    logic                       mem_resp_val, mem_resp_nack;
    logic [MEM_TAG_BITS-1:0]    mem_resp_tag;
    logic                       tag_err;

    int n_total = 0;
    int n_bad   = 0;

    localparam logic [31:0] DC_ADDR  = 32'hD000_0000;
    localparam logic [31:0] ICC_ADDR = 32'hC000_0004;
    localparam logic [31:0] ICV_ADDR = 32'hB000_0008;

    mem_refill_arbiter #(.MAX_OUT(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .dc_mem_req_val    (dc_mem_req_val),
        .dc_mem_req_rdy    (dc_mem_req_rdy),
        .dc_mem_req_rw     (dc_mem_req_rw),
        .dc_mem_req_addr   (dc_mem_req_addr),
        .dc_mem_req_tag    (dc_mem_req_tag),
        .icc_mem_req_val   (icc_mem_req_val),
        .icc_mem_req_rdy   (icc_mem_req_rdy),
        .icc_mem_req_addr  (icc_mem_req_addr),
        .icc_mem_req_tag   (icc_mem_req_tag),
        .icv_mem_req_val   (icv_mem_req_val),
        .icv_mem_req_rdy   (icv_mem_req_rdy),
        .icv_mem_req_addr  (icv_mem_req_addr),
        .icv_mem_req_tag   (icv_mem_req_tag),
        .dc_mem_resp_val   (dc_mem_resp_val),
        .dc_mem_resp_nack  (dc_mem_resp_nack),
        .icc_mem_resp_val  (icc_mem_resp_val),
        .icc_mem_resp_nack (icc_mem_resp_nack),
        .icv_mem_resp_val  (icv_mem_resp_val),
        .icv_mem_resp_nack (icv_mem_resp_nack),
        .mem_req_val       (mem_req_val),
        .mem_req_rdy       (mem_req_rdy),
        .mem_req_rw        (mem_req_rw),
        .mem_req_addr      (mem_req_addr),
        .mem_req_tag       (mem_req_tag),
        .mem_resp_val      (mem_resp_val),
        .mem_resp_nack     (mem_resp_nack),
        .mem_resp_tag      (mem_resp_tag),
        .tag_err           (tag_err)
    );

    always #5 clk = ~clk;

    logic [2:0]  rdy_vec, resp_vec, nack_vec;
    logic [39:0] payload;
    logic [8:0]  cnt_all;
    assign rdy_vec  = {icv_mem_req_rdy, icc_mem_req_rdy, dc_mem_req_rdy};
    assign resp_vec = {icv_mem_resp_val, icc_mem_resp_val, dc_mem_resp_val};
    assign nack_vec = {icv_mem_resp_nack, icc_mem_resp_nack, dc_mem_resp_nack};
    assign payload  = {mem_req_rw, mem_req_tag, mem_req_addr};
    assign cnt_all  = {dut.cnt_q[2], dut.cnt_q[1], dut.cnt_q[0]};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        dc_mem_req_val = 1'b0; icc_mem_req_val = 1'b0; icv_mem_req_val = 1'b0;
        mem_req_rdy    = 1'b0; mem_resp_val    = 1'b0; mem_resp_nack   = 1'b0;
        mem_resp_tag   = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    logic [39:0] exp_pl [3];
    logic [2:0]  exp_rdy;

    initial begin
        reset            = 1'b0;
        clear_inputs();
        dc_mem_req_rw    = 1'b1;
        dc_mem_req_addr  = DC_ADDR;
        dc_mem_req_tag   = 5'h0A;
        icc_mem_req_addr = ICC_ADDR;
        icc_mem_req_tag  = 1'b1;
        icv_mem_req_addr = ICV_ADDR;
        icv_mem_req_tag  = 1'b0;
        exp_pl[0] = {1'b1, 7'h0A, DC_ADDR};
        exp_pl[1] = {1'b0, 7'h21, ICC_ADDR};
        exp_pl[2] = {1'b0, 7'h40, ICV_ADDR};

        // Reset values; request val follows eligible inputs even in reset.
        #2;
        check("rst_val_idle", mem_req_val, 0);
        check("rst_tag_err", tag_err, 0);
        check("rst_cnt", cnt_all, 0);
        dc_mem_req_val = 1'b1;
        #1;
        check("rst_val_follow", mem_req_val, 1);
        dc_mem_req_val = 1'b0;
        step();
        reset = 1'b1;
        step();

        // All ports valid, rdy high: 0,1,2 rotation until each holds 4 credits.
        dc_mem_req_val = 1'b1; icc_mem_req_val = 1'b1; icv_mem_req_val = 1'b1;
        mem_req_rdy = 1'b1;
        for (int k = 0; k < 12; k++) begin
            #1;
            exp_rdy = 3'b001 << (k % 3);
            check("rr_rdy", rdy_vec, exp_rdy);
            check("rr_payload", payload, exp_pl[k % 3]);
            step();
        end
        #1;
        check("rr_stall_val", mem_req_val, 0);
        check("rr_stall_rdy", rdy_vec, 0);
        check("rr_cnt_full", cnt_all, {3'd4, 3'd4, 3'd4});

        // Drain: responses steered by tag top bits.
        clear_inputs();
        for (int k = 0; k < 12; k++) begin
            mem_resp_val = 1'b1;
            mem_resp_tag = {2'(k % 3), 5'h00};
            #1;
            exp_rdy = 3'b001 << (k % 3);
            check("drain_resp", resp_vec, exp_rdy);
            step();
        end
        mem_resp_val = 1'b0;
        #1;
        check("drain_cnt", cnt_all, 0);
        check("drain_tag_err", tag_err, 0);

        // Grant lock: port 1 held through 5 stall cycles while port 0 arrives.
        icc_mem_req_val = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k == 1) dc_mem_req_val = 1'b1;
            #1;
            check("hold_rdy", rdy_vec, 0);
            check("hold_payload", payload, exp_pl[1]);
            step();
        end
        mem_req_rdy = 1'b1;
        #1;
        check("hold_accept_rdy", rdy_vec, 3'b010);
        check("hold_accept_payload", payload, exp_pl[1]);
        step();
        icc_mem_req_val = 1'b0;
        #1;
        check("hold_next_rdy", rdy_vec, 3'b001);
        check("hold_next_payload", payload, exp_pl[0]);
        step();
        dc_mem_req_val = 1'b0;
        #1;
        check("hold_cnt", cnt_all, {3'd0, 3'd1, 3'd1});

        // Port 0 saturated, port 2 granted; a port 0 response reopens it.
        do_reset();
        dc_mem_req_val = 1'b1;
        mem_req_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("sat_fill_rdy", rdy_vec, 3'b001);
            step();
        end
        icv_mem_req_val = 1'b1;
        icv_mem_req_tag = 1'b1;
        #1;
        check("sat_icv_rdy", rdy_vec, 3'b100);
        check("sat_icv_payload", payload, {1'b0, 7'h41, ICV_ADDR});
        step();
        icv_mem_req_val = 1'b0;
        mem_resp_val = 1'b1;
        mem_resp_tag = 7'h03;
        #1;
        check("sat_dc_blocked", mem_req_val, 0);
        check("sat_dc_resp", resp_vec, 3'b001);
        step();
        mem_resp_val = 1'b0;
        #1;
        check("sat_cnt0", cnt_all, {3'd1, 3'd0, 3'd3});
        check("sat_dc_reopen", rdy_vec, 3'b001);
        step();
        dc_mem_req_val = 1'b0;
        mem_resp_val = 1'b1;
        mem_resp_tag = 7'h41;
        #1;
        check("icv_resp_only", resp_vec, 3'b100);
        check("icv_resp_nack", nack_vec, 3'b000);
        step();
        mem_resp_val = 1'b0;
        #1;
        check("icv_cnt", cnt_all, {3'd0, 3'd0, 3'd4});

        // Accept plus nack on port 0 in one cycle at cnt=2.
        do_reset();
        dc_mem_req_val = 1'b1;
        mem_req_rdy = 1'b1;
        step();
        step();
        mem_resp_nack = 1'b1;
        mem_resp_tag = 7'h00;
        #1;
        check("nack_strobe", nack_vec, 3'b001);
        check("nack_no_resp", resp_vec, 3'b000);
        check("nack_accept", rdy_vec, 3'b001);
        step();
        dc_mem_req_val = 1'b0;
        mem_resp_nack = 1'b0;
        #1;
        check("nack_cnt", cnt_all, {3'd0, 3'd0, 3'd2});

        // Port field 3 is a tag error: no strobes, sticky flag.
        mem_resp_val = 1'b1;
        mem_resp_tag = 7'h60;
        #1;
        check("bad_tag_resp", resp_vec, 3'b000);
        step();
        mem_resp_val = 1'b0;
        #1;
        check("bad_tag_set", tag_err, 1);
        step();
        step();
        check("bad_tag_sticky", tag_err, 1);

        // Reset mid-HOLD drops the lock and clears counters immediately.
        mem_req_rdy = 1'b0;
        icc_mem_req_val = 1'b1;
        step();
        dc_mem_req_val = 1'b1;
        #1;
        check("mid_hold_state", dut.state_q, ST_HOLD);
        check("mid_hold_port", mem_req_tag[6:5], 2'd1);
        reset = 1'b0;
        #1;
        check("async_state", dut.state_q, ST_IDLE);
        check("async_cnt", cnt_all, 0);
        check("async_tag_err", tag_err, 0);
        check("async_port", mem_req_tag[6:5], 2'd0);
        check("async_val", mem_req_val, 1);
        step();
        reset = 1'b1;
        clear_inputs();
        step();

        // Response to an idle port underflows and flags tag_err.
        mem_resp_val = 1'b1;
        mem_resp_tag = 7'h20;
        #1;
        check("uflow_resp", resp_vec, 3'b010);
        step();
        mem_resp_val = 1'b0;
        #1;
        check("uflow_tag_err", tag_err, 1);
        check("uflow_cnt", cnt_all, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_refill_arbiter.md
# mem_refill_arbiter

Round-robin arbiter that shares the single memory refill port between the data cache (port 0), the control-thread instruction cache (port 1) and the vector-thread instruction cache (port 2). It replaces fixed-priority muxing with fair, grant-locked arbitration and per-port outstanding-request limits, and steers responses and nacks back by tag. It sits between the three cache refill interfaces and the memory request/response channel.

## Interface
- `MAX_OUT`, default 4: maximum outstanding (accepted, unanswered) requests per port; 1..7.
- `clk` input 1: clock.
- `reset` input 1: asynchronous, active-low reset.
- `dc_mem_req_val` / `dc_mem_req_rdy` input / output 1: port 0 request handshake.
- `dc_mem_req_rw` input 1: port 0 read (0) / write (1).
- `dc_mem_req_addr` input `MEM_ADDR_BITS: port 0 address.
- `dc_mem_req_tag` input `DC_MEM_TAG_BITS: port 0 tag.
- `icc_mem_req_val` / `icc_mem_req_rdy`, `icc_mem_req_addr`, `icc_mem_req_tag` (1 bit): port 1 request, read only.
- `icv_mem_req_val` / `icv_mem_req_rdy`, `icv_mem_req_addr`, `icv_mem_req_tag` (1 bit): port 2 request, read only.
- `{dc,icc,icv}_mem_resp_val`, `{dc,icc,icv}_mem_resp_nack` output 1: per-port response and nack strobes.
- `mem_req_val` output 1, `mem_req_rdy` input 1, `mem_req_rw` output 1, `mem_req_addr` output `MEM_ADDR_BITS, `mem_req_tag` output `MEM_TAG_BITS: downstream request.
- `mem_resp_val`, `mem_resp_nack` input 1, `mem_resp_tag` input `MEM_TAG_BITS: downstream response.
- `tag_err` output 1: sticky; set on a response/nack whose port field is 2'd3.

## Operation
- Tag encoding: top 2 bits = port id (0 dc, 1 icc, 2 icv); the low `DC_MEM_TAG_BITS` carry the requester tag. Icache tags are zero-extended. rw is forced to 0 for ports 1 and 2.
- Eligible(i) = req_val(i) & (cnt(i) < MAX_OUT).
- State IDLE: if any port is eligible, select the first eligible port at or after `rr_ptr`, cyclic order 0→1→2→0. Drive its request downstream. If `mem_req_rdy` is high, the request is accepted and the state stays IDLE. Otherwise latch `grant` and go to HOLD.
- State HOLD: drive only `grant`'s request. No re-arbitration takes place. Leave HOLD on `mem_req_rdy`. The requester must keep val and payload stable. If `grant`'s val drops, this is a protocol violation; the arbiter returns to IDLE with nothing accepted.
- On accept of port g: `rr_ptr` ← (g+1) mod 3 and cnt(g) += 1.
- Only the selected port sees rdy: req_rdy(i) = mem_req_rdy & selected==i & mem_req_val.
- Response steering: resp_val(i) = mem_resp_val & tag[MSB:MSB-1]==i. Nack is steered the same way. Either event decrements cnt(i). Nacked requests are reissued by the requester.
- A port's accept and response in the same cycle leave cnt unchanged.
- Decrement at cnt==0 is a saturating no-op and sets `tag_err`.

## Timing
- Arbitration and steering are combinational from inputs and state; accept-to-counter update takes 1 cycle.
- Reset values: state IDLE, `rr_ptr`=0, `grant`=0, all cnt=0, `tag_err`=0.
- Outputs during reset: `mem_req_val` follows eligible inputs combinationally. Reset asserted mid-HOLD drops the lock immediately; counters clear, so any responses in flight after reset raise `tag_err` if they underflow.
- Worst-case wait for an eligible, stable requester is 2 accepted grants.

## Structure
- Shared package/header (riscvConst.vh): `MEM_TAG_BITS, `DC_MEM_TAG_BITS, port-id constants PORT_DC=0, PORT_ICC=1, PORT_ICV=2, and the state encoding.
- One sub-module, `rr_pick3`: combinational 3-way round-robin selector (eligible[2:0], ptr → one-hot sel, any).

## Test plan
- All three ports valid continuously, `mem_req_rdy`=1, no responses, `MAX_OUT`=4 → grant order 0,1,2,0,1,2…. Each port stalls after 4 accepts; cnt=4 each.
- Port 1 valid, `mem_req_rdy` low for 5 cycles, then port 0 raises val → addr/tag stay on port 1 for all cycles and port 1 is accepted first; port 0 is accepted next cycle.
- Port 0 at cnt=4 and port 2 valid → port 2 is granted. A port 0 response with tag top bits 0 → cnt(0)=3 and port 0 becomes eligible the next cycle.
- Port 2 accept with icv tag 1 → `mem_req_tag`={2'd2,0…,1}, rw=0. A response with tag 2'd2 → only `icv_mem_resp_val` is pulsed.
- Accept and nack on port 0 in the same cycle at cnt=2 → `dc_mem_resp_nack`=1 and cnt stays 2.
- Response with tag top bits 2'd3 → no per-port strobe and `tag_err`=1 until reset. Asserting reset mid-HOLD → state IDLE and all counters 0 immediately.
